layer_4_fmap_sequencer: RTL

- Controller that streams one layer-4 input tensor (IMG_SIZE x IMG_SIZE pixels, 32 channels packed into DATA_IN_WIDTH bits) from the feature-map buffer into the shared 32-channel 3x3 convolution datapath.
- Inserts the 1-pixel zero-padding border.
- Repeats the pass once per output feature map, NUM_FMAP times.
- Counts the datapath's results so it knows when each pass has drained, and sequences the pass index fmap_sel, which selects the datapath's weight set.

---
 rtl/layer_4_fmap_sequencer_if.sv | 33 +++
 rtl/layer_4_fmap_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/layer_4_fmap_sequencer_if.sv
// Handshake and bus bundle between the layer-4 fmap sequencer, the feature-map
// buffer and the shared 3x3 convolution datapath.
interface layer_4_fmap_sequencer_if #(
  parameter int DATA_IN_WIDTH = 1024,
  parameter int ADDR_WIDTH    = 14,
  parameter int FMAP_WIDTH    = 6
);
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     rd_en;
  logic [ADDR_WIDTH-1:0]    rd_addr;
  logic [DATA_IN_WIDTH-1:0] rd_data;
  logic [DATA_IN_WIDTH-1:0] pixel_out;
  logic                     pixel_valid;
  logic                     pixel_ready;
  logic [FMAP_WIDTH-1:0]    fmap_sel;
  logic                     fmap_start;
  logic                     res_valid;
  logic                     err;

  modport master (
    input  start, rd_data, pixel_ready, res_valid,
    output busy, done, rd_en, rd_addr, pixel_out, pixel_valid,
           fmap_sel, fmap_start, err
  );

  modport slave (
    output start, rd_data, pixel_ready, res_valid,
    input  busy, done, rd_en, rd_addr, pixel_out, pixel_valid,
           fmap_sel, fmap_start, err
  );
endinterface

// File: rtl/layer_4_fmap_sequencer.sv
// Streams one zero-padded layer-4 tensor into the conv datapath once per output
// fmap, counting datapath results to know when each pass has drained.
module layer_4_fmap_sequencer #(
  parameter int IMG_SIZE      = 104,
  parameter int DATA_IN_WIDTH = 1024,
  parameter int NUM_FMAP      = 64,
  parameter int ADDR_WIDTH    = 14,
  parameter int FMAP_WIDTH    = 6
) (
  input logic                     Clk,
  input logic                     Rst,
  layer_4_fmap_sequencer_if.master bus
);

  localparam int RC_W  = $clog2(IMG_SIZE + 2);
  localparam int CNT_W = $clog2(IMG_SIZE * IMG_SIZE + 1);

  localparam logic [RC_W-1:0]       RC_IMG    = RC_W'(IMG_SIZE);
  localparam logic [RC_W-1:0]       RC_LAST   = RC_W'(IMG_SIZE + 1);
  localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(IMG_SIZE * IMG_SIZE);
  localparam logic [FMAP_WIDTH-1:0] FMAP_LAST = FMAP_WIDTH'(NUM_FMAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_STREAM, S_DRAIN, S_FIN} state_e;

  state_e                   state_q, state_d;
  logic [RC_W-1:0]          r_q, r_d, c_q, c_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic                     s1_q, s1_d;
  logic                     z1_q, z1_d;
  logic                     last_q, last_d;
  logic [DATA_IN_WIDTH-1:0] pix_q, pix_d;
  logic                     pvld_q, pvld_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [FMAP_WIDTH-1:0]    fsel_q, fsel_d;
  logic                     err_q, err_d;

  logic slot_free, advance, interior, issue, rd_en_c;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      addr_q  <= '0;
      s1_q    <= 1'b0;
      z1_q    <= 1'b0;
      last_q  <= 1'b0;
      pix_q   <= '0;
      pvld_q  <= 1'b0;
      cnt_q   <= '0;
      fsel_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      addr_q  <= addr_d;
      s1_q    <= s1_d;
      z1_q    <= z1_d;
      last_q  <= last_d;
      pix_q   <= pix_d;
      pvld_q  <= pvld_d;
      cnt_q   <= cnt_d;
      fsel_q  <= fsel_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    addr_d  = addr_q;
    s1_d    = s1_q;
    z1_d    = z1_q;
    last_d  = last_q;
    pix_d   = pix_q;
    pvld_d  = pvld_q;
    cnt_d   = cnt_q;
    fsel_d  = fsel_q;
    err_d   = err_q;
    rd_en_c = 1'b0;

    slot_free = !pvld_q || bus.pixel_ready;
    advance   = !s1_q || slot_free;
    interior  = (r_q != '0) && (r_q <= RC_IMG) && (c_q != '0) && (c_q <= RC_IMG);
    issue     = (state_q == S_STREAM) && !last_q && advance;

    // Output stage: stage-1 entry moves into the output register when it frees up.
    if (s1_q && slot_free) begin
      pix_d  = z1_q ? '0 : bus.rd_data;
      pvld_d = 1'b1;
      s1_d   = 1'b0;
    end else if (pvld_q && bus.pixel_ready) begin
      pvld_d = 1'b0;
    end

    // Issue stage: the running address tracks (r-1)*IMG_SIZE+(c-1) without a multiplier.
    if (issue) begin
      s1_d = 1'b1;
      z1_d = !interior;
      if (interior) begin
        rd_en_c = 1'b1;
        addr_d  = addr_q + 1'b1;
      end
      if (c_q == RC_LAST) begin
        c_d = '0;
        if (r_q == RC_LAST) last_d = 1'b1;
        else                r_d    = r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_PREP;
          fsel_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_PREP: begin
        r_d     = '0;
        c_d     = '0;
        addr_d  = '0;
        cnt_d   = '0;
        last_d  = 1'b0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (last_q && !s1_q && !pvld_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_q == CNT_FULL) begin
          if (fsel_q == FMAP_LAST) begin
            state_d = S_FIN;
          end else begin
            fsel_d  = fsel_q + 1'b1;
            state_d = S_PREP;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Results outside a pass, or beyond a full pass, are protocol errors.
    if (bus.res_valid) begin
      if (state_q == S_STREAM || state_q == S_DRAIN) begin
        if (cnt_q == CNT_FULL) err_d = 1'b1;
        else                   cnt_d = cnt_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_FIN);
  assign bus.fmap_start  = (state_q == S_PREP);
  assign bus.rd_en       = rd_en_c;
  assign bus.rd_addr     = rd_en_c ? addr_q : '0;
  assign bus.pixel_out   = pix_q;
  assign bus.pixel_valid = pvld_q;
  assign bus.fmap_sel    = fsel_q;
  assign bus.err         = err_q;

endmodule
